// File: rtl/mem_io_unit.sv
// Data-memory / memory-mapped I/O access unit (RAM loads, stores, LED, seven-segment, switches).
// Latency: RAM load 3 cycles (2 stalled), I/O load same cycle, stores one cycle.
// Backpressure: stall held while a RAM load is in flight. Byte access enabled by MEMIO_BYTE_ACCESS_EN.
module mem_io_unit #(
   parameter int          RAM_ADDR_W = 14,
   parameter logic [31:0] IO_BASE    = 32'hFFFFFC00
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [31:0]           addr,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  byte_access,
   input  logic                  load_unsigned,
   input  logic [31:0]           write_data,
   output logic [31:0]           mem_data,
   output logic                  stall,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   output logic                  ram_we,
   output logic [3:0]            ram_be,
   input  logic [31:0]           ram_rdata,
   input  logic [23:0]           switch_in,
   output logic [23:0]           led_out,
   output logic [31:0]           seg_out
);

   localparam logic [31:0] LED_ADDR = IO_BASE + 32'h60;
   localparam logic [31:0] SW_ADDR  = IO_BASE + 32'h70;
   localparam logic [31:0] SEG_ADDR = IO_BASE + 32'h80;

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

   state_t      state;
   logic [31:0] rd_buf;
   logic [23:0] sw_meta;
   logic [23:0] sw_sync;

   logic        byte_en;
   logic        zext;
   logic        is_io;
   logic        is_ram;
   logic        is_led;
   logic        is_sw;
   logic        is_seg;
   logic        wr_ok;
   logic        ram_load;
   logic [7:0]  lane_byte;
   logic [31:0] lane_ext;

`ifdef MEMIO_BYTE_ACCESS_EN
   assign byte_en = byte_access;
   assign zext    = load_unsigned;
`else
   // Word-only build: byte controls and the lane bits of the address have no effect.
   assign byte_en = 1'b0;
   assign zext    = 1'b0;
   logic unused_byte_ctrl;
   assign unused_byte_ctrl = ^{byte_access, load_unsigned, addr[1:0]};
`endif

   // I/O registers are decoded on the word address so lane bits never miss a register.
   assign is_io  = (addr >= IO_BASE);
   assign is_ram = ~is_io;
   assign is_led = is_io && (addr[31:2] == LED_ADDR[31:2]);
   assign is_sw  = is_io && (addr[31:2] == SW_ADDR[31:2]);
   assign is_seg = is_io && (addr[31:2] == SEG_ADDR[31:2]);

   // A simultaneous read wins; the store half of the request is dropped.
   assign wr_ok    = (state == IDLE) && mem_write && !mem_read;
   assign ram_load = (state == IDLE) && mem_read && is_ram;

   // Stall is forced low during reset so the CPU is never frozen while held in reset.
   assign stall = reset_n && (ram_load || (state == RD_WAIT));

   assign ram_addr  = addr[RAM_ADDR_W+1:2];
   assign ram_we    = wr_ok && is_ram;
   assign ram_be    = byte_en ? (4'b0001 << addr[1:0]) : 4'b1111;
   assign ram_wdata = byte_en ? {4{write_data[7:0]}} : write_data;

   assign lane_byte = rd_buf[{addr[1:0], 3'b000} +: 8];
   assign lane_ext  = zext ? {24'h000000, lane_byte} : {{24{lane_byte[7]}}, lane_byte};

   // Load result: buffered RAM word in RD_DONE, live I/O value for an I/O read in IDLE.
   always_comb begin
      mem_data = 32'h0;
      if (state == RD_DONE) begin
         mem_data = byte_en ? lane_ext : rd_buf;
      end else if ((state == IDLE) && mem_read && is_sw) begin
         mem_data = {8'h00, sw_sync};
      end
   end

   // Load sequencer: launch, wait one cycle for RAM data, present it for one cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         rd_buf <= 32'h0;
      end else begin
         case (state)
            IDLE:    if (ram_load) state <= RD_WAIT;
            RD_WAIT: begin
               rd_buf <= ram_rdata;
               state  <= RD_DONE;
            end
            RD_DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Two-flop synchronizer for the asynchronous board switches.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sw_meta <= 24'h0;
         sw_sync <= 24'h0;
      end else begin
         sw_meta <= switch_in;
         sw_sync <= sw_meta;
      end
   end

   // Output registers; a byte store only touches lane 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         led_out <= 24'h0;
         seg_out <= 32'h0;
      end else if (wr_ok) begin
         if (is_led) begin
            if (byte_en) led_out[7:0] <= write_data[7:0];
            else         led_out      <= write_data[23:0];
         end
         if (is_seg) begin
            if (byte_en) seg_out[7:0] <= write_data[7:0];
            else         seg_out      <= write_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed bench for mem_io_unit: table of single-cycle store / I/O-read vectors
// plus hand-written multi-cycle load, switch-sync and reset sequences.
module tb_mem_io_unit;

   logic        clock;
   logic        reset_n;
   logic [31:0] addr;
   logic        mem_read;
   logic        mem_write;
   logic        byte_access;
   logic        load_unsigned;
   logic [31:0] write_data;
   logic [31:0] mem_data;
   logic        stall;
   logic [13:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_rdata;
   logic [23:0] switch_in;
   logic [23:0] led_out;
   logic [31:0] seg_out;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] LED = 32'hFFFFFC60;
   localparam logic [31:0] SW  = 32'hFFFFFC70;
   localparam logic [31:0] SEG = 32'hFFFFFC80;
   localparam logic [31:0] UNM = 32'hFFFFFC90;

   mem_io_unit dut (
      .clock(clock), .reset_n(reset_n), .addr(addr), .mem_read(mem_read),
      .mem_write(mem_write), .byte_access(byte_access), .load_unsigned(load_unsigned),
      .write_data(write_data), .mem_data(mem_data), .stall(stall), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_be(ram_be), .ram_rdata(ram_rdata),
      .switch_in(switch_in), .led_out(led_out), .seg_out(seg_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous-read RAM model, preloaded only.
   logic [31:0] mem [0:63];
   always @(posedge clock) ram_rdata <= mem[ram_addr[5:0]];

   typedef struct {
      logic [31:0] a;
      logic        rd, wr, ba, lu;
      logic [31:0] wd;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic [31:0] e_md;
      logic [23:0] e_led;
      logic [31:0] e_seg;
      logic        ck_ra;
      logic [13:0] e_ra;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic addv(input logic [31:0] a, input logic rd, wr, ba, lu, input logic [31:0] wd,
                       input logic e_we, input logic [3:0] e_be, input logic [31:0] e_wd, e_md,
                       input logic [23:0] e_led, input logic [31:0] e_seg,
                       input logic ck_ra, input logic [13:0] e_ra);
      vec_t v;
      v.a = a; v.rd = rd; v.wr = wr; v.ba = ba; v.lu = lu; v.wd = wd;
      v.e_we = e_we; v.e_be = e_be; v.e_wd = e_wd; v.e_md = e_md;
      v.e_led = e_led; v.e_seg = e_seg; v.ck_ra = ck_ra; v.e_ra = e_ra;
      vq.push_back(v);
   endtask

   // Three-cycle RAM load; successive calls are back-to-back loads.
   task automatic do_load(input string name, input logic [31:0] a, input logic wr, ba, lu,
                          input logic [31:0] exp);
      @(negedge clock);
      addr = a; mem_read = 1'b1; mem_write = wr; byte_access = ba; load_unsigned = lu;
      write_data = 32'h5A5A5A5A;
      #1;
      check({name, "_c0_stall"}, 32'(stall), 32'd1);
      check({name, "_c0_raddr"}, 32'(ram_addr), 32'(a[15:2]));
      check({name, "_c0_we"}, 32'(ram_we), 32'd0);
      @(negedge clock);
      check({name, "_c1_stall"}, 32'(stall), 32'd1);
      check({name, "_c1_data"}, mem_data, 32'd0);
      check({name, "_c1_we"}, 32'(ram_we), 32'd0);
      @(negedge clock);
      check({name, "_c2_stall"}, 32'(stall), 32'd0);
      check({name, "_c2_data"}, mem_data, exp);
      check({name, "_c2_we"}, 32'(ram_we), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4]  = 32'h12345678;   // byte address 0x10
      mem[8]  = 32'hCAFEF00D;   // byte address 0x20
      mem[12] = 32'h80FFFFFF;   // byte address 0x30..0x33

      reset_n = 1'b0; addr = 32'h10; mem_read = 1'b1; mem_write = 1'b0;
      byte_access = 1'b0; load_unsigned = 1'b0; write_data = 32'h0; switch_in = 24'h0;
      #2;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_mdata", mem_data, 32'd0);
      check("rst_led", 32'(led_out), 32'd0);
      check("rst_seg", seg_out, 32'd0);
      mem_read = 1'b0; addr = 32'h0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      // Switch synchronizer: visible exactly two edges after the change.
      @(negedge clock);
      addr = SW; mem_read = 1'b1; switch_in = 24'h00A5A5;
      #1;
      check("sw_t0", mem_data, 32'd0);
      @(negedge clock);
      check("sw_t1", mem_data, 32'd0);
      @(negedge clock);
      check("sw_t2", mem_data, 32'h0000A5A5);
      mem_read = 1'b0;

      // addr rd wr ba lu wdata | we be ram_wdata mem_data led seg ck_ra ra
      addv(32'h40, 0, 1, 0, 0, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 0, 24'h0, 32'h0, 1, 14'h10);
      addv(LED,    0, 1, 0, 0, 32'hABCDEF01, 0, 4'hF, 32'hABCDEF01, 0, 24'hCDEF01, 32'h0, 0, 0);
      addv(SEG,    0, 1, 0, 0, 32'hABCDEF01, 0, 4'hF, 32'hABCDEF01, 0, 24'hCDEF01, 32'hABCDEF01, 0, 0);
      addv(SW,     1, 0, 0, 0, 32'h0, 0, 4'hF, 32'h0, 32'h0000A5A5, 24'hCDEF01, 32'hABCDEF01, 0, 0);
      addv(UNM,    0, 1, 0, 0, 32'h11111111, 0, 4'hF, 32'h11111111, 0, 24'hCDEF01, 32'hABCDEF01, 0, 0);
      addv(UNM,    1, 0, 0, 0, 32'h0, 0, 4'hF, 32'h0, 0, 24'hCDEF01, 32'hABCDEF01, 0, 0);
      addv(LED,    1, 0, 0, 0, 32'h0, 0, 4'hF, 32'h0, 0, 24'hCDEF01, 32'hABCDEF01, 0, 0);
      addv(LED,    1, 1, 0, 0, 32'h12345678, 0, 4'hF, 32'h12345678, 0, 24'hCDEF01, 32'hABCDEF01, 0, 0);
      addv(32'h43, 0, 1, 0, 0, 32'h01020304, 1, 4'hF, 32'h01020304, 0, 24'hCDEF01, 32'hABCDEF01, 1, 14'h10);
      addv(32'h0,  0, 0, 0, 0, 32'h0, 0, 4'hF, 32'h0, 0, 24'hCDEF01, 32'hABCDEF01, 0, 0);
      addv(LED,    0, 1, 0, 0, 32'h00123456, 0, 4'hF, 32'h00123456, 0, 24'h123456, 32'hABCDEF01, 0, 0);
`ifdef MEMIO_BYTE_ACCESS_EN
      addv(LED,    0, 1, 1, 0, 32'h00000077, 0, 4'h1, 32'h77777777, 0, 24'h123477, 32'hABCDEF01, 0, 0);
      addv(32'h41, 0, 1, 1, 0, 32'hAABBCCDD, 1, 4'h2, 32'hDDDDDDDD, 0, 24'h123477, 32'hABCDEF01, 1, 14'h10);
      addv(32'hFFFFFC83, 0, 1, 1, 0, 32'h000000EE, 0, 4'h8, 32'hEEEEEEEE, 0, 24'h123477, 32'hABCDEFEE, 0, 0);
      addv(SW,     1, 1, 0, 0, 32'h0, 0, 4'hF, 32'h0, 32'h0000A5A5, 24'h123477, 32'hABCDEFEE, 0, 0);
`else
      addv(LED,    0, 1, 1, 0, 32'h00000077, 0, 4'hF, 32'h00000077, 0, 24'h000077, 32'hABCDEF01, 0, 0);
      addv(32'h41, 0, 1, 1, 0, 32'hAABBCCDD, 1, 4'hF, 32'hAABBCCDD, 0, 24'h000077, 32'hABCDEF01, 1, 14'h10);
      addv(32'hFFFFFC83, 0, 1, 1, 0, 32'h000000EE, 0, 4'hF, 32'h000000EE, 0, 24'h000077, 32'h000000EE, 0, 0);
      addv(SW,     1, 1, 0, 0, 32'h0, 0, 4'hF, 32'h0, 32'h0000A5A5, 24'h000077, 32'h000000EE, 0, 0);
`endif

      foreach (vq[i]) begin
         @(negedge clock);
         addr = vq[i].a; mem_read = vq[i].rd; mem_write = vq[i].wr;
         byte_access = vq[i].ba; load_unsigned = vq[i].lu; write_data = vq[i].wd;
         #1;
         check($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
         check($sformatf("v%0d_we", i), 32'(ram_we), 32'(vq[i].e_we));
         check($sformatf("v%0d_be", i), 32'(ram_be), 32'(vq[i].e_be));
         check($sformatf("v%0d_wdata", i), ram_wdata, vq[i].e_wd);
         check($sformatf("v%0d_mdata", i), mem_data, vq[i].e_md);
         if (vq[i].ck_ra) check($sformatf("v%0d_raddr", i), 32'(ram_addr), 32'(vq[i].e_ra));
         @(posedge clock);
         #1;
         check($sformatf("v%0d_led", i), 32'(led_out), 32'(vq[i].e_led));
         check($sformatf("v%0d_seg", i), seg_out, vq[i].e_seg);
      end
      @(negedge clock);
      mem_read = 1'b0; mem_write = 1'b0; byte_access = 1'b0;

      // Word load, then a back-to-back read/write conflict that must behave as a load.
      do_load("ldw", 32'h10, 1'b0, 1'b0, 1'b0, 32'h12345678);
      do_load("ldc", 32'h20, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
`ifdef MEMIO_BYTE_ACCESS_EN
      do_load("lbs", 32'h33, 1'b0, 1'b1, 1'b0, 32'hFFFFFF80);
      do_load("lbu", 32'h33, 1'b0, 1'b1, 1'b1, 32'h00000080);
`else
      do_load("lbs", 32'h33, 1'b0, 1'b1, 1'b0, 32'h80FFFFFF);
      do_load("lbu", 32'h33, 1'b0, 1'b1, 1'b1, 32'h80FFFFFF);
`endif
      @(negedge clock);
      mem_read = 1'b0; mem_write = 1'b0; byte_access = 1'b0; load_unsigned = 1'b0;

      // Reset asserted while the load is in RD_WAIT.
      @(negedge clock);
      addr = 32'h20; mem_read = 1'b1;
      @(negedge clock);
      check("rw_pre_stall", 32'(stall), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rw_stall", 32'(stall), 32'd0);
      check("rw_mdata", mem_data, 32'd0);
      check("rw_led", 32'(led_out), 32'd0);
      check("rw_seg", seg_out, 32'd0);
      mem_read = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("rel_stall", 32'(stall), 32'd0);
      check("rel_led", 32'(led_out), 32'd0);
      check("rel_seg", seg_out, 32'd0);
      do_load("ldr", 32'h10, 1'b0, 1'b0, 1'b0, 32'h12345678);
      @(negedge clock);
      mem_read = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
